// File: rtl/iir_conv_scheduler_pkg.sv
// ============================================================================
// Module   : iir_conv_scheduler_pkg
// Brief    : Shared types and defaults for the IIR converter scheduler.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package iir_conv_scheduler_pkg;

   localparam logic [31:0] SAT_VAL_DEF = 32'h4780_0000;
   localparam int          TIMEOUT_DEF = 32;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ROUTE} sched_st_t;
   typedef enum logic {PATH_IN, PATH_OUT} path_t;

   typedef struct packed {
      logic [31:0] data;
      logic        valid;
   } slot_t;

endpackage

`default_nettype wire

// File: rtl/iir_conv_scheduler_if.sv
// ============================================================================
// Module   : iir_conv_scheduler_if
// Brief    : Sample/filter handshakes, converter port and block outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface iir_conv_scheduler_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [2:0]  opt_i;
   logic [2:0]  opt_o;
   logic        flt_valid;
   logic        flt_ready;
   logic [31:0] flt_data;
   logic        f_en;
   logic [31:0] f_data;
   logic        cv_start;
   logic [31:0] cv_dataa;
   logic [2:0]  cv_n;
   logic        cv_done;
   logic [31:0] cv_result;
   logic        o_valid;
   logic [31:0] o_signal;
   logic        err_tmo;

   modport slave (
      input  in_valid, in_data, opt_i, opt_o, flt_valid, flt_data, cv_done, cv_result,
      output in_ready, flt_ready, f_en, f_data, cv_start, cv_dataa, cv_n,
             o_valid, o_signal, err_tmo
   );

   modport master (
      output in_valid, in_data, opt_i, opt_o, flt_valid, flt_data, cv_done, cv_result,
      input  in_ready, flt_ready, f_en, f_data, cv_start, cv_dataa, cv_n,
             o_valid, o_signal, err_tmo
   );
endinterface

`default_nettype wire

// File: rtl/iir_conv_scheduler_rr_arb2.sv
// ============================================================================
// Module   : iir_conv_scheduler_rr_arb2
// Brief    : Two-way round-robin grant; ties go to the path not granted last.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module iir_conv_scheduler_rr_arb2
   import iir_conv_scheduler_pkg::*;
(
   input  logic  clk,
   input  logic  reset_l,
   input  logic  req_in,
   input  logic  req_out,
   input  logic  take,
   output path_t grant,
   output logic  grant_v
);

   path_t last;

   always_comb begin
      grant_v = req_in | req_out;
      if (req_in && req_out)
         grant = (last == PATH_IN) ? PATH_OUT : PATH_IN;
      else if (req_out)
         grant = PATH_OUT;
      else
         grant = PATH_IN;
   end

   always_ff @(posedge clk) begin
      if (!reset_l)
         last <= PATH_IN;
      else if (take)
         last <= grant;
   end

endmodule

`default_nettype wire

// File: rtl/iir_conv_scheduler.sv
// ============================================================================
// Module   : iir_conv_scheduler
// Brief    : Shares one multi-cycle int<->float converter between the IIR input
//            and output paths. Optional macro SAT_CLEAR_EN zeroes saturated
//            input-path results.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module iir_conv_scheduler
   import iir_conv_scheduler_pkg::*;
#(
   parameter int          TIMEOUT = TIMEOUT_DEF,
   parameter logic [31:0] SAT_VAL = SAT_VAL_DEF
)(
   input  logic               clk,
   input  logic               reset_l,
   iir_conv_scheduler_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

`ifdef SAT_CLEAR_EN
   localparam logic SAT_CLR = 1'b1;
`else
   localparam logic SAT_CLR = 1'b0;
`endif

   slot_t          in_slot;
   slot_t          out_slot;
   sched_st_t      state;
   path_t          job_path;
   logic [TW-1:0]  timer;
   path_t          grant;
   logic           grant_v;
   logic           take;
   logic [31:0]    in_res;

   assign bus.in_ready  = !in_slot.valid;
   assign bus.flt_ready = !out_slot.valid;
   assign take          = (state == IDLE) && grant_v;
   assign in_res        = (SAT_CLR && (bus.cv_result == SAT_VAL)) ? 32'h0 : bus.cv_result;

   iir_conv_scheduler_rr_arb2 u_arb (
      .clk     (clk),
      .reset_l (reset_l),
      .req_in  (in_slot.valid),
      .req_out (out_slot.valid),
      .take    (take),
      .grant   (grant),
      .grant_v (grant_v)
   );

   // A slot is freed on the edge its job is granted; capture needs the slot empty,
   // so capture and release of the same slot never collide.
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         in_slot  <= '0;
         out_slot <= '0;
      end else begin
         if (take && grant == PATH_IN)
            in_slot.valid <= 1'b0;
         else if (bus.in_valid && !in_slot.valid)
            in_slot <= '{data: bus.in_data, valid: 1'b1};

         if (take && grant == PATH_OUT)
            out_slot.valid <= 1'b0;
         else if (bus.flt_valid && !out_slot.valid)
            out_slot <= '{data: bus.flt_data, valid: 1'b1};
      end
   end

   // Timer counts cycles since cv_start; a done arriving as it hits TIMEOUT still wins.
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state        <= IDLE;
         job_path     <= PATH_IN;
         timer        <= '0;
         bus.cv_start <= 1'b0;
         bus.cv_dataa <= '0;
         bus.cv_n     <= '0;
         bus.f_en     <= 1'b0;
         bus.f_data   <= '0;
         bus.o_valid  <= 1'b0;
         bus.o_signal <= '0;
         bus.err_tmo  <= 1'b0;
      end else begin
         bus.cv_start <= 1'b0;
         bus.f_en     <= 1'b0;
         bus.o_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_v) begin
                  state        <= ISSUE;
                  job_path     <= grant;
                  timer        <= '0;
                  bus.cv_start <= 1'b1;
                  if (grant == PATH_IN) begin
                     bus.cv_dataa <= in_slot.data;
                     bus.cv_n     <= bus.opt_i;
                  end else begin
                     bus.cv_dataa <= out_slot.data;
                     bus.cv_n     <= bus.opt_o;
                  end
               end
            end
            ISSUE: begin
               state <= WAIT;
               timer <= TW'(1);
            end
            WAIT: begin
               if (bus.cv_done) begin
                  state <= ROUTE;
                  if (job_path == PATH_IN) begin
                     bus.f_en   <= 1'b1;
                     bus.f_data <= in_res;
                  end else begin
                     bus.o_valid  <= 1'b1;
                     bus.o_signal <= bus.cv_result;
                  end
               end else if (timer == TW'(TIMEOUT)) begin
                  state       <= IDLE;
                  bus.err_tmo <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ROUTE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
